// File: rtl/int_to_fp_seq.sv
// Sequential signed-integer to 13-bit float {sign, exp[3:0], frac[7:0]} converter.
// Optional round-half-up stage enabled by defining INT_TO_FP_ROUND_EN.
module int_to_fp_seq #(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [IN_W-1:0] din,
    output logic            ready,
    output logic            done,
    output logic [12:0]     fp_out,
    output logic            ovf
);

`ifdef INT_TO_FP_ROUND_EN
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [IN_W-1:0] sreg_q, sreg_d;
    logic [4:0]      exp_q, exp_d;
    logic            sign_q, sign_d;
    logic [12:0]     fp_q, fp_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      frac_w;

    assign frac_w = sreg_q[IN_W-1 -: 8];

`ifdef INT_TO_FP_ROUND_EN
    logic [8:0] rsum_w;
    logic [4:0] rexp_w;
    logic [7:0] rfrac_w;

    assign rsum_w  = {1'b0, frac_w} + 9'(sreg_q[IN_W-9]);
    assign rexp_w  = rsum_w[8] ? exp_q + 5'd1 : exp_q;
    assign rfrac_w = rsum_w[8] ? 8'h80 : rsum_w[7:0];
`endif

    // Exponents beyond 4 bits saturate to the largest finite magnitude.
    function automatic logic [13:0] pack(input logic s,
                                         input logic [4:0] e,
                                         input logic [7:0] f);
        if (e > 5'd15)
            return {1'b1, s, 4'hF, 8'hFF};
        else
            return {1'b0, s, e[3:0], f};
    endfunction

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        fp_d    = fp_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = din[IN_W-1];
                    sreg_d  = din[IN_W-1] ? IN_W'(-din) : din;
                    exp_d   = 5'(IN_W);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (sreg_q == '0) begin
                    fp_d    = '0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end else if (sreg_q[IN_W-1]) begin
`ifdef INT_TO_FP_ROUND_EN
                    state_d = ROUND;
`else
                    {ovf_d, fp_d} = pack(sign_q, exp_q, frac_w);
                    state_d = DONE;
`endif
                end else begin
                    sreg_d = {sreg_q[IN_W-2:0], 1'b0};
                    exp_d  = exp_q - 5'd1;
                end
            end
`ifdef INT_TO_FP_ROUND_EN
            ROUND: begin
                {ovf_d, fp_d} = pack(sign_q, rexp_w, rfrac_w);
                state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            fp_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            fp_q    <= fp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign fp_out = fp_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed scoreboard bench for int_to_fp_seq (IN_W=16).
// Expected values follow INT_TO_FP_ROUND_EN when it is defined.
module tb_int_to_fp_seq;

    localparam int IN_W = 16;
`ifdef INT_TO_FP_ROUND_EN
    localparam int R = 1;
`else
    localparam int R = 0;
`endif

    typedef struct {
        logic [12:0] fp;
        logic        ovf;
        int          lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [IN_W-1:0] din = '0;
    logic            ready;
    logic            done;
    logic [12:0]     fp_out;
    logic            ovf;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   d0;
    exp_t sb[$];

    int_to_fp_seq #(.IN_W(IN_W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .din    (din),
        .ready  (ready),
        .done   (done),
        .fp_out (fp_out),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic conv(input logic [15:0] d, input logic [12:0] efp,
                        input logic eovf, input int elat,
                        input int inj, input bit dinj);
        exp_t e;
        int   cnt;
        int   s0;
        @(negedge clk);
        din   = d;
        start = 1'b1;
        sb.push_back('{efp, eovf, elat});
        s0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        din   = 16'($urandom);
        cnt   = 1;
        while (done !== 1'b1 && cnt < 40) begin
            chk("ready_busy", 32'(ready), 32'd0);
            if (cnt == inj) begin
                start = 1'b1;
                din   = 16'h4000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        chk("done_timeout", 32'(done), 32'd1);
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("fp_out", 32'(fp_out), 32'(e.fp));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("latency", 32'(cnt), 32'(e.lat));
        end
        if (dinj) begin
            start = 1'b1;
            din   = 16'h4000;
        end
        @(negedge clk);
        start = 1'b0;
        chk("ready_after", 32'(ready), 32'd1);
        chk("done_pulse", 32'(done), 32'd0);
        chk("fp_hold", 32'(fp_out), 32'(efp));
        chk("one_done", 32'(done_cnt - s0), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fp", 32'(fp_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        conv(16'h0001, 13'h0180, 1'b0, 17 + R, 0, 1'b0);
        conv(16'hFFFF, 13'h1180, 1'b0, 17 + R, 0, 1'b0);
        conv(16'h0000, 13'h0000, 1'b0, 2, 0, 1'b0);
        conv(16'h0181, R ? 13'h09C1 : 13'h09C0, 1'b0, 9 + R, 0, 1'b0);
        conv(16'hFE7F, R ? 13'h19C1 : 13'h19C0, 1'b0, 9 + R, 0, 1'b0);
        conv(16'h7FFF, 13'h0FFF, R ? 1'b1 : 1'b0, 3 + R, 0, 1'b0);
        conv(16'h8000, 13'h1FFF, 1'b1, 2 + R, 0, 1'b0);
        conv(16'h00FF, 13'h08FF, 1'b0, 10 + R, 0, 1'b0);

        d0 = done_cnt;
        conv(16'h0001, 13'h0180, 1'b0, 17 + R, 3, 1'b1);
        repeat (25) @(negedge clk);
        chk("no_extra_done", 32'(done_cnt - d0), 32'd1);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_fp_hold", 32'(fp_out), 32'h0180);

        @(negedge clk);
        din   = 16'h0001;
        start = 1'b1;
        d0    = done_cnt;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_ready", 32'(ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_fp", 32'(fp_out), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        conv(16'h0100, 13'h0980, 1'b0, 9 + R, 0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
